// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: sample-rate sequencer for the echo/delay effect.
// It accepts one audio sample per handshake. For each sample it reads the
// delayed sample from the circular-buffer RAM, then writes the new sample into
// the same single-port RAM. The output is y = x + delayed/2, saturated to the
// sample range. When the echo is disabled, the output is x unchanged.
module delay_line_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            options,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [DATA_WIDTH-1:0] x,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // One extra bit so fill can reach SIZE and pointer arithmetic can hold wr_ptr+SIZE.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    WR   = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [CW-1:0]           fill;
  logic [DATA_WIDTH-1:0]   x_lat;
  logic                    en_lat;
  logic [CW-1:0]           d_lat;

  logic [CW-1:0]           d_sel;
  logic [CW-1:0]           wr_ext;
  logic [CW-1:0]           rd_sel;
  logic [DATA_WIDTH-1:0]   dly;
  logic [DATA_WIDTH-1:0]   dly_half;
  logic [DATA_WIDTH:0]     sum;
  logic [DATA_WIDTH-1:0]   sum_sat;
  logic [DATA_WIDTH-1:0]   y_mix;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  assign x_ready = (state == IDLE);

  // Delay selection and read address for the sample being offered this cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    d_sel  = CW'(1);
    wr_ext = {1'b0, wr_ptr};
    rd_sel = '0;
    if (int'(options) >= SIZE) begin
      d_sel = CW'(SIZE - 1);
    end else if (options != 4'd0) begin
      d_sel = CW'(options);
    end
    // The buffer depth need not be a power of two, so wrap the address explicitly.
    if (wr_ext >= d_sel) begin
      rd_sel = wr_ext - d_sel;
    end else begin
      rd_sel = wr_ext + CW'(SIZE) - d_sel;
    end
  end

  // Echo mix. The buffer entry is used only once D samples have been written since reset.
  always_comb begin
    dly      = '0;
    dly_half = '0;
    sum      = '0;
    sum_sat  = '0;
    y_mix    = x_lat;
    if (fill >= d_lat) begin
      dly = ram_rdata;
    end
    dly_half = DATA_WIDTH'($signed(dly) >>> 1);
    sum      = {x_lat[DATA_WIDTH-1], x_lat} + {dly_half[DATA_WIDTH-1], dly_half};
    // A sign mismatch between the two top bits means the sum left the W-bit range.
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      sum_sat = sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_sat = sum[DATA_WIDTH-1:0];
    end
    if (en_lat) begin
      y_mix = sum_sat;
    end
  end

  // Sequencer: accept, read the delayed sample, write the new one, present y.
  // NOTE: state and registered outputs use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      x_lat     <= '0;
      en_lat    <= 1'b0;
      d_lat     <= CW'(1);
      y         <= '0;
      y_valid   <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      y_valid <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (x_valid) begin
            x_lat    <= x;
            en_lat   <= en;
            d_lat    <= d_sel;
            ram_addr <= rd_sel[ADDR_WIDTH-1:0];
            state    <= RD;
          end
        end
        RD: begin
          state <= WAIT;
        end
        WAIT: begin
          // ram_rdata holds the delayed sample now, so the result and the write are issued together.
          y         <= y_mix;
          y_valid   <= 1'b1;
          ram_addr  <= wr_ptr;
          ram_we    <= 1'b1;
          ram_wdata <= x_lat;
          state     <= WR;
        end
        WR: begin
          wr_ptr <= (wr_ptr == ADDR_WIDTH'(SIZE - 1)) ? '0 : wr_ptr + 1'b1;
          if (fill < CW'(SIZE)) begin
            fill <= fill + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
